sb_wait_ram: RTL and testbench

SB_WAIT_RAM -- requirements
Module: sb_wait_ram

---
 rtl/sb_wait_ram_if.sv | 31 +++
 rtl/sb_wait_ram.sv | 139 +++++++++++++
 tb/tb_sb_wait_ram.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_wait_ram_if.sv
// System-bus port bundle for the wait-state RAM: initiator drives the request
// fields, the RAM returns registered read data and a one-cycle ready strobe.
interface sb_wait_ram_if;
    logic        req_i;
    logic        write_enable_i;
    logic [3:0]  byte_enable_i;
    logic [31:0] addr_i;
    logic [31:0] write_data_i;
    logic [31:0] read_data_o;
    logic        ready_o;

    modport master (
        output req_i,
        output write_enable_i,
        output byte_enable_i,
        output addr_i,
        output write_data_i,
        input  read_data_o,
        input  ready_o
    );

    modport slave (
        input  req_i,
        input  write_enable_i,
        input  byte_enable_i,
        input  addr_i,
        input  write_data_i,
        output read_data_o,
        output ready_o
    );
endinterface

// File: rtl/sb_wait_ram.sv
// Word-organised RAM on the system bus with a fixed number of wait cycles
// between request capture and the single-cycle ready response.
module sb_wait_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    sb_wait_ram_if.slave bus
);

    localparam int unsigned AW          = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LP_CNT_INIT = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic          w_go_resp;

    logic          r_we;
    logic [3:0]    r_be;
    logic [31:2]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_capture;
    logic          w_we;
    logic [3:0]    w_be;
    logic [31:2]   w_addr;
    logic [31:0]   w_wdata;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic          w_mem_we;
    logic          w_unused;

    // Byte offset within the word plays no role in a word-organised RAM.
    assign w_unused  = ^bus.addr_i[1:0];

    assign w_capture = (r_state == ST_IDLE) && bus.req_i;

    // With zero wait cycles the capture edge is also the RESP-entry edge, so the
    // memory access must use the live inputs rather than the holding registers.
    always_comb begin
        w_we    = r_we;
        w_be    = r_be;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        if (r_state == ST_IDLE) begin
            w_we    = bus.write_enable_i;
            w_be    = bus.byte_enable_i;
            w_addr  = bus.addr_i[31:2];
            w_wdata = bus.write_data_i;
        end
    end

    assign w_in_range = (w_addr[31:AW+2] == '0);
    assign w_idx      = w_addr[AW+1:2];
    assign w_mem_we   = w_go_resp && w_we && w_in_range && !rst_i;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_go_resp   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_i) begin
                    if (LATENCY == 0) begin
                        w_state_nxt = ST_RESP;
                        w_go_resp   = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = LP_CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                    w_go_resp   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_we    <= bus.write_enable_i;
                r_be    <= bus.byte_enable_i;
                r_addr  <= bus.addr_i[31:2];
                r_wdata <= bus.write_data_i;
            end
            if (w_go_resp && !w_we) begin
                r_rdata <= w_in_range ? r_mem[w_idx] : '0;
            end
        end
    end

    // Array deliberately has no reset so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    assign bus.ready_o     = (r_state == ST_RESP);
    assign bus.read_data_o = r_rdata;

endmodule

// File: tb/tb_sb_wait_ram.sv
// Randomised self-checking bench for sb_wait_ram: one instance with two wait
// cycles and a 1024-word array, one with zero wait cycles and a 16-word array.
module tb_sb_wait_ram;

    localparam int unsigned DEPTH_A = 1024;
    localparam int unsigned LAT_A   = 2;
    localparam int unsigned DEPTH_B = 16;
    localparam int unsigned LAT_B   = 0;

    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_a [DEPTH_A];
    logic [31:0] mem_b [DEPTH_B];
    logic [31:0] last_rd [2];

    sb_wait_ram_if u_if_a ();
    sb_wait_ram_if u_if_b ();

    sb_wait_ram #(.DEPTH_WORDS(DEPTH_A), .LATENCY(LAT_A)) u_dut_a (
        .clk_i (clk),
        .rst_i (rst_a),
        .bus   (u_if_a)
    );

    sb_wait_ram #(.DEPTH_WORDS(DEPTH_B), .LATENCY(LAT_B)) u_dut_b (
        .clk_i (clk),
        .rst_i (rst_b),
        .bus   (u_if_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned depth_of(input int sel);
        return (sel == 0) ? DEPTH_A : DEPTH_B;
    endfunction

    function automatic int unsigned lat_of(input int sel);
        return (sel == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic drive(input int sel, input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel == 0) begin
            u_if_a.req_i = req; u_if_a.write_enable_i = we; u_if_a.byte_enable_i = be;
            u_if_a.addr_i = addr; u_if_a.write_data_i = wdata;
        end else begin
            u_if_b.req_i = req; u_if_b.write_enable_i = we; u_if_b.byte_enable_i = be;
            u_if_b.addr_i = addr; u_if_b.write_data_i = wdata;
        end
    endtask

    task automatic sample(input int sel, output logic rdy, output logic [31:0] rd);
        if (sel == 0) begin
            rdy = u_if_a.ready_o; rd = u_if_a.read_data_o;
        end else begin
            rdy = u_if_b.ready_o; rd = u_if_b.read_data_o;
        end
    endtask

    function automatic logic [31:0] model_rd(input int sel, input logic [31:0] addr);
        if (addr >= 4 * depth_of(sel)) return 32'h0;
        return (sel == 0) ? mem_a[addr / 4] : mem_b[addr / 4];
    endfunction

    task automatic model_wr(input int sel, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata);
        logic [31:0] mask;
        logic [31:0] old;
        if (addr >= 4 * depth_of(sel)) return;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        old  = model_rd(sel, addr);
        if (sel == 0) mem_a[addr / 4] = (old & ~mask) | (wdata & mask);
        else          mem_b[addr / 4] = (old & ~mask) | (wdata & mask);
    endtask

    // Starts at a falling edge with the DUT idle; ends one falling edge after the
    // response, again with the DUT idle. Inputs are scrambled during wait cycles.
    task automatic do_txn(input int sel, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd_seen);
        logic        rdy;
        logic [31:0] rd;
        logic [31:0] exp_rd;
        int          first;
        exp_rd  = we ? last_rd[sel] : model_rd(sel, addr);
        first   = 0;
        rd_seen = '0;
        drive(sel, 1'b1, we, be, addr, wdata);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            sample(sel, rdy, rd);
            if (rdy) begin
                first   = n;
                rd_seen = rd;
                break;
            end
            drive(sel, 1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom);
        end
        drive(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk(we ? "ready_latency_wr" : "ready_latency_rd", first, lat_of(sel) + 1);
        chk(we ? "rdata_hold_on_wr" : "rdata_read", rd_seen, exp_rd);
        @(negedge clk);
        sample(sel, rdy, rd);
        chk("ready_one_cycle", {31'b0, rdy}, 32'h0);
        if (we) model_wr(sel, be, addr, wdata);
        else    last_rd[sel] = exp_rd;
    endtask

    task automatic hold_req(input int sel, input logic [31:0] addr, input int ncyc);
        logic        rdy;
        logic [31:0] rd;
        logic [31:0] exp_rd;
        int unsigned period;
        int          pulses;
        period = lat_of(sel) + 2;
        exp_rd = model_rd(sel, addr);
        pulses = 0;
        drive(sel, 1'b1, 1'b0, 4'hF, addr, 32'h0);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            sample(sel, rdy, rd);
            if (k == ncyc) drive(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            chk("held_req_ready", {31'b0, rdy}, {31'b0, (k % period) == (lat_of(sel) + 1)});
            if (rdy) begin
                pulses++;
                chk("held_req_rdata", rd, exp_rd);
            end
        end
        chk("held_req_pulses", pulses, (ncyc + 1) / period);
        last_rd[sel] = exp_rd;
    endtask

    task automatic reset_mid_txn(input logic [31:0] addr, input int abort_cycle);
        logic        rdy;
        logic [31:0] rd;
        drive(0, 1'b1, 1'b1, 4'hF, addr, 32'h5555_5555);
        for (int k = 1; k <= abort_cycle; k++) begin
            @(negedge clk);
            drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
        rst_a = 1'b1;
        #1;
        sample(0, rdy, rd);
        chk("rst_ready", {31'b0, rdy}, 32'h0);
        chk("rst_rdata", rd, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sample(0, rdy, rd);
            chk("rst_held_ready", {31'b0, rdy}, 32'h0);
        end
        rst_a = 1'b0;
        last_rd[0] = 32'h0;
    endtask

    task automatic rand_txn(input int sel);
        logic [31:0] addr;
        logic [31:0] rd;
        int unsigned depth;
        depth = depth_of(sel);
        if ($urandom_range(0, 7) == 0) begin
            addr = ($urandom_range(0, 1) == 1) ? ($urandom | 32'h8000_0000)
                                               : (4 * depth + $urandom_range(0, 255));
        end else begin
            addr = $urandom_range(0, depth - 1) * 4 + $urandom_range(0, 3);
        end
        do_txn(sel, 1'($urandom), 4'($urandom), addr, $urandom, rd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rdy;
        logic [31:0] rd;
        logic [31:0] word0;

        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #2;
        sample(0, rdy, rd);
        chk("reset_ready_a", {31'b0, rdy}, 32'h0);
        chk("reset_rdata_a", rd, 32'h0);
        sample(1, rdy, rd);
        chk("reset_ready_b", {31'b0, rdy}, 32'h0);
        chk("reset_rdata_b", rd, 32'h0);
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Fill both arrays so every later read has a known expectation.
        for (int unsigned i = 0; i < DEPTH_A; i++) do_txn(0, 1'b1, 4'hF, i * 4, $urandom, rd);
        for (int unsigned i = 0; i < DEPTH_B; i++) do_txn(1, 1'b1, 4'hF, i * 4, $urandom, rd);

        do_txn(0, 1'b1, 4'hF, 32'h10, 32'hCAFE_F00D, rd);
        do_txn(0, 1'b0, 4'h0, 32'h10, 32'h0, rd);
        chk("cafe_read", rd, 32'hCAFE_F00D);

        do_txn(0, 1'b1, 4'hF, 32'h20, 32'h1122_3344, rd);
        do_txn(0, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, rd);
        do_txn(0, 1'b0, 4'hF, 32'h20, 32'h0, rd);
        chk("lane_merge", rd, 32'h11BB_33DD);
        do_txn(0, 1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF, rd);
        do_txn(0, 1'b0, 4'b1010, 32'h20, 32'h0, rd);
        chk("be_zero_write", rd, 32'h11BB_33DD);

        word0 = mem_a[0];
        do_txn(0, 1'b0, 4'hF, 32'h1000, 32'h0, rd);
        chk("oor_read", rd, 32'h0);
        do_txn(0, 1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF, rd);
        do_txn(0, 1'b0, 4'hF, 32'h0, 32'h0, rd);
        chk("oor_no_alias", rd, word0);
        do_txn(1, 1'b1, 4'hF, 32'h40, 32'hFFFF_FFFF, rd);
        do_txn(1, 1'b0, 4'hF, 32'h0, 32'h0, rd);
        do_txn(1, 1'b0, 4'hF, 32'h3C, 32'h0, rd);

        hold_req(0, 32'h20, 8);
        hold_req(1, 32'h8, 8);

        do_txn(0, 1'b1, 4'hF, 32'h40, 32'h0, rd);
        do_txn(0, 1'b1, 4'hF, 32'h44, 32'h0, rd);
        reset_mid_txn(32'h40, 1);
        do_txn(0, 1'b0, 4'hF, 32'h40, 32'h0, rd);
        chk("rst_abort_wait", rd, 32'h0);
        reset_mid_txn(32'h44, 2);
        do_txn(0, 1'b0, 4'hF, 32'h44, 32'h0, rd);
        chk("rst_abort_resp_entry", rd, 32'h0);

        for (int i = 0; i < 40; i++) do_txn(1, 1'b0, 4'($urandom), $urandom_range(0, 63), 32'h0, rd);

        for (int i = 0; i < 200; i++) begin
            rand_txn(0);
            rand_txn(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
